irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of request inputs (legal 1..8).
REQ-002 SHALL have parameter BASE, default 8'hF0, port address of register 0.
REQ-003 SHALL have parameter VBASE, default 4'h0, vector of channel 0.
REQ-004 SHALL have parameter ROTATE, default 0: 0 = fixed priority (channel 0 highest), 1 = rotating priority.
REQ-005 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-007 SHALL have port ce, input, 1, clock enable; when 0, no state changes.
REQ-008 SHALL have port req, input, CHANNELS, asynchronous interrupt sources.
REQ-009 SHALL have port iff1, input, 1, CPU interrupt-enable flag.
REQ-010 SHALL have port port_addr, input, 8, I/O port address.
REQ-011 SHALL have port port_din, input, 8, I/O write data.
REQ-012 SHALL have port port_we, input, 1, I/O write strobe, one cycle.
REQ-013 SHALL have port port_rd, input, 1, I/O read strobe.
REQ-014 SHALL have port port_dout, output, 8, register read data.
REQ-015 SHALL have port irq, output, 1, interrupt request to the CPU.
REQ-016 SHALL have port vect, output, 4, vector of the requested channel.

Function
REQ-017 SHALL pass each req bit through a 2-flop synchroniser; all following logic uses the synchronised value s.
REQ-018 SHALL keep registers MASK at BASE+0 (R/W, 1 = masked), PEND at BASE+1 (R; write 1 clears bit), ISR at BASE+2 (R; any write = EOI), and MODE at BASE+3 (R/W, 1 = edge, 0 = level). Bits >= CHANNELS read 0 and ignore writes.
REQ-019 SHALL in edge mode set PEND[k] on the cycle after s[k] rises (0 to 1); in level mode PEND[k] SHALL follow s[k] with one cycle of delay.
REQ-020 SHALL let edge set win over a write-1-clear of PEND[k] in the same cycle.
REQ-021 SHALL drive port_dout combinationally from the addressed register while port_rd=1 and the address is in BASE..BASE+3; otherwise port_dout SHALL be 8'h00.
REQ-022 SHALL treat channel k as eligible when PEND[k]=1, MASK[k]=0 and k ranks above every ISR bit; with ISR empty, all unmasked pending channels are eligible.
REQ-023 SHALL rank channels from LOW (a register, reset 0) upward modulo CHANNELS; LOW stays 0 when ROTATE=0.
REQ-024 SHALL run FSM IDLE -> ASSERT -> IDLE.
REQ-025 IDLE: if any channel is eligible, SHALL latch the highest-ranked channel c, set irq=1, set vect=VBASE+c (4-bit wrap) and go to ASSERT on the next edge.
REQ-026 ASSERT: acknowledge is iff1 registered 1 with current iff1=0 while irq=1. On acknowledge, SHALL set ISR[c], clear PEND[c] in edge mode, set irq=0 and return to IDLE.
REQ-027 ASSERT: if c stops being eligible before acknowledge (masked or level dropped), SHALL set irq=0 and return to IDLE without changing ISR. The latched c SHALL NOT change while in ASSERT.
REQ-028 EOI SHALL clear the highest-ranked set ISR bit. If ROTATE=1, it SHALL set LOW to (that channel+1) mod CHANNELS. EOI with ISR=0 has no effect.
REQ-029 SHALL make irq=1 at the earliest 4 edges after req rises: 2 sync, 1 PEND, 1 FSM.
REQ-030 SHALL ignore ports and all inputs except reset while ce=0; synchroniser flops still run.

Reset
REQ-031 Reset SHALL immediately set MASK=8'hFF, PEND=0, ISR=0, MODE=0, LOW=0, synchronisers=0, FSM=IDLE, irq=0 and vect=VBASE, including when asserted mid-ASSERT.
REQ-032 After reset release, no irq SHALL occur until software clears MASK.

Verification
REQ-033 MASK=0, MODE=FF, pulse req[3] for 1 cycle -> PEND=08 and irq=1 with vect=3 on the 4th edge; iff1 1->0 -> irq=0, ISR=08, PEND=00.
REQ-034 req[5] and req[2] rise together, fixed priority -> vect=2 first; after acknowledge of 2, req[5] gives no irq until EOI; after EOI -> vect=5.
REQ-035 ISR=20 (channel 5 in service), req[1] edge -> nested irq with vect=1; req[6] edge -> no irq.
REQ-036 Level mode on channel 0, drop req[0] while in ASSERT -> irq=0 within 3 edges, ISR unchanged.
REQ-037 ROTATE=1, EOI of channel 2 -> LOW=3; req[1] and req[4] rise together -> vect=4.
REQ-038 Reset asserted during ASSERT -> irq=0 and MASK=FF immediately; read BASE+0 -> FF.

Source files
------------

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: synchronised requests, MASK/PEND/ISR/MODE port
// registers, fixed or rotating priority with nesting, and a two-state request FSM.
module irq_ctrl #(
    parameter int         CHANNELS = 8,
    parameter logic [7:0] BASE     = 8'hF0,
    parameter logic [3:0] VBASE    = 4'h0,
    parameter bit         ROTATE   = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ce,
    input  logic [CHANNELS-1:0] req,
    input  logic                iff1,
    input  logic [7:0]          port_addr,
    input  logic [7:0]          port_din,
    input  logic                port_we,
    input  logic                port_rd,
    output logic [7:0]          port_dout,
    output logic                irq,
    output logic [3:0]          vect
);
    localparam logic [7:0] CH_MASK = 8'((9'd1 << CHANNELS) - 9'd1);

    typedef enum logic {ST_IDLE, ST_ASSERT} state_t;

    logic [7:0] req_w, sync1_q, sync2_q, s_prev_q, rise_s;
    logic [7:0] mask_q, mask_d, pend_q, pend_d, isr_q, isr_d, mode_q, mode_d;
    logic [2:0] low_q, low_d, chan_q, chan_d;
    state_t     state_q, state_d;
    logic       irq_q, irq_d, iff1_q;
    logic [3:0] vect_q, vect_d;

    logic [7:0] offset_s, cand_s, elig_s, w1c_s, ack_clr_s, eoi_clr_s;
    logic       in_range_s, wr_mask_s, wr_pend_s, wr_isr_s, wr_mode_s;
    logic       isr_any_s, any_elig_s, ack_s;
    logic [2:0] isr_top_s, best_c_s;

    assign req_w = 8'(req);
    assign irq   = irq_q;
    assign vect  = vect_q;

    // Port address decode; offset arithmetic wraps so BASE near 8'hFF still works.
    always_comb begin
        offset_s   = port_addr - BASE;
        in_range_s = (offset_s < 8'd4);
        wr_mask_s  = ce && port_we && in_range_s && (offset_s[1:0] == 2'd0);
        wr_pend_s  = ce && port_we && in_range_s && (offset_s[1:0] == 2'd1);
        wr_isr_s   = ce && port_we && in_range_s && (offset_s[1:0] == 2'd2);
        wr_mode_s  = ce && port_we && in_range_s && (offset_s[1:0] == 2'd3);
    end

    // Register read mux, combinational while the read strobe is held.
    always_comb begin
        port_dout = 8'h00;
        if (port_rd && in_range_s) begin
            case (offset_s[1:0])
                2'd0:    port_dout = mask_q;
                2'd1:    port_dout = pend_q;
                2'd2:    port_dout = isr_q;
                2'd3:    port_dout = mode_q;
                default: port_dout = 8'h00;
            endcase
        end else begin
            port_dout = 8'h00;
        end
    end

    // Walk channels from LOW in rank order: first ISR bit blocks everything below it.
    always_comb begin
        logic [2:0] ch;
        ch         = 3'd0;
        cand_s     = pend_q & ~mask_q & CH_MASK;
        elig_s     = 8'h00;
        isr_any_s  = 1'b0;
        isr_top_s  = 3'd0;
        any_elig_s = 1'b0;
        best_c_s   = 3'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch = 3'((int'(low_q) + i) % CHANNELS);
            if (isr_q[ch]) begin
                if (!isr_any_s) isr_top_s = ch; else isr_top_s = isr_top_s;
                isr_any_s = 1'b1;
            end else if (cand_s[ch] && !isr_any_s) begin
                elig_s[ch] = 1'b1;
                if (!any_elig_s) best_c_s = ch; else best_c_s = best_c_s;
                any_elig_s = 1'b1;
            end else begin
                elig_s[ch] = elig_s[ch];
            end
        end
    end

    // Request FSM: latch the winner, then wait for acknowledge or loss of eligibility.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        irq_d   = irq_q;
        vect_d  = vect_q;
        ack_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig_s) begin
                    chan_d  = best_c_s;
                    irq_d   = 1'b1;
                    vect_d  = VBASE + 4'(best_c_s);
                    state_d = ST_ASSERT;
                end else begin
                    irq_d = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (iff1_q && !iff1 && irq_q) begin
                    ack_s   = 1'b1;
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (!elig_s[chan_q] || (!mode_q[chan_q] && !sync2_q[chan_q])) begin
                    // a level source that has already dropped is released without waiting for PEND
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ASSERT;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next state of the software-visible registers and the rotation pointer.
    always_comb begin
        rise_s    = sync2_q & ~s_prev_q;
        w1c_s     = wr_pend_s ? port_din : 8'h00;
        ack_clr_s = ack_s ? (8'd1 << chan_q) : 8'h00;
        eoi_clr_s = (wr_isr_s && isr_any_s) ? (8'd1 << isr_top_s) : 8'h00;
        mask_d    = wr_mask_s ? (port_din & CH_MASK) : mask_q;
        mode_d    = wr_mode_s ? (port_din & CH_MASK) : mode_q;
        // edge set beats both write-1-clear and acknowledge clear
        pend_d    = ((mode_q & (rise_s | (pend_q & ~w1c_s & ~ack_clr_s))) |
                     (~mode_q & sync2_q)) & CH_MASK;
        isr_d     = ((isr_q & ~eoi_clr_s) | (8'd1 << chan_q & {8{ack_s}})) & CH_MASK;
        if (ROTATE && wr_isr_s && isr_any_s) begin
            low_d = (isr_top_s == 3'(CHANNELS - 1)) ? 3'd0 : isr_top_s + 3'd1;
        end else begin
            low_d = low_q;
        end
    end

    // Two-flop request synchroniser, free-running regardless of ce.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= req_w;
            sync2_q <= sync1_q;
        end
    end

    // Controller state, frozen while ce is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_prev_q <= 8'h00;
            mask_q   <= CH_MASK;
            pend_q   <= 8'h00;
            isr_q    <= 8'h00;
            mode_q   <= 8'h00;
            low_q    <= 3'd0;
            state_q  <= ST_IDLE;
            chan_q   <= 3'd0;
            irq_q    <= 1'b0;
            vect_q   <= VBASE;
            iff1_q   <= 1'b0;
        end else if (ce) begin
            s_prev_q <= sync2_q;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            isr_q    <= isr_d;
            mode_q   <= mode_d;
            low_q    <= low_d;
            state_q  <= state_d;
            chan_q   <= chan_d;
            irq_q    <= irq_d;
            vect_q   <= vect_d;
            iff1_q   <= iff1;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a fixed-priority and a rotating instance share stimulus;
// expected vectors come from a rank-arithmetic priority model.
module tb_irq_ctrl;
    localparam logic [7:0] BASE = 8'hF0;
    localparam logic [3:0] VB1  = 4'hC;

    logic       clock = 1'b0;
    logic       reset, ce, iff1, port_we, port_rd;
    logic [7:0] req, port_addr, port_din;
    logic [7:0] dout0, dout1;
    logic       irq0, irq1;
    logic [3:0] vect0, vect1;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    irq_ctrl #(.CHANNELS(8), .BASE(BASE), .VBASE(4'h0), .ROTATE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .ce(ce), .req(req), .iff1(iff1),
        .port_addr(port_addr), .port_din(port_din), .port_we(port_we),
        .port_rd(port_rd), .port_dout(dout0), .irq(irq0), .vect(vect0));

    irq_ctrl #(.CHANNELS(8), .BASE(BASE), .VBASE(VB1), .ROTATE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .ce(ce), .req(req), .iff1(iff1),
        .port_addr(port_addr), .port_din(port_din), .port_we(port_we),
        .port_rd(port_rd), .port_dout(dout1), .irq(irq1), .vect(vect1));

    // Highest-ranked member of set when ranking starts at low; -1 when empty.
    function automatic int first_ch(input logic [7:0] set, input int low);
        int best = -1;
        int best_rank = 8;
        for (int k = 0; k < 8; k++) begin
            if (set[k] && ((k - low + 8) % 8) < best_rank) begin
                best = k;
                best_rank = (k - low + 8) % 8;
            end
        end
        return best;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ce = 1'b1; iff1 = 1'b0; port_we = 1'b0; port_rd = 1'b0;
        req = 8'h00; port_addr = 8'h00; port_din = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_addr = a; port_din = d; port_we = 1'b1;
        tick(1);
        port_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d0, output logic [7:0] d1);
        port_addr = a; port_rd = 1'b1;
        #1;
        d0 = dout0; d1 = dout1;
        port_rd = 1'b0;
    endtask

    task automatic ack_cpu();
        iff1 = 1'b1;
        tick(1);
        iff1 = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        logic [7:0] d0, d1;
        do_reset();
        checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b/%b want 0/0", irq0, irq1); end
        checks++; if (vect0 !== 4'h0 || vect1 !== VB1) begin errors++; $display("FAIL reset_vect: got %h/%h want 0/%h", vect0, vect1, VB1); end
        rd(BASE, d0, d1);
        checks++; if (d0 !== 8'hFF || d1 !== 8'hFF) begin errors++; $display("FAIL reset_mask: got %h/%h want ff", d0, d1); end
        rd(BASE + 8'd1, d0, d1);
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", d0); end
        rd(BASE + 8'd3, d0, d1);
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_mode: got %h want 00", d0); end
        tick(1);
        rd(8'h10, d0, d1);
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rd_outside: got %h want 00", d0); end
        req = 8'($urandom_range(1, 255));
        tick(6);
        checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("FAIL masked_after_reset: got %b/%b want 0", irq0, irq1); end
        req = 8'h00;
    endtask

    task automatic test_edge_basic();
        logic [7:0] d0, d1;
        do_reset();
        wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
        req = 8'h08; tick(1); req = 8'h00; tick(2);
        rd(BASE + 8'd1, d0, d1);
        checks++; if (d0 !== 8'h08) begin errors++; $display("FAIL edge_pend: got %h want 08", d0); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL edge_irq_early: got %b want 0", irq0); end
        tick(1);
        checks++; if (irq0 !== 1'b1 || vect0 !== 4'h3) begin errors++; $display("FAIL edge_irq4: got irq %b vect %h want 1/3", irq0, vect0); end
        checks++; if (vect1 !== 4'hF) begin errors++; $display("FAIL vbase_vect: got %h want f", vect1); end
        ack_cpu();
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL ack_irq: got %b want 0", irq0); end
        rd(BASE + 8'd2, d0, d1);
        checks++; if (d0 !== 8'h08) begin errors++; $display("FAIL ack_isr: got %h want 08", d0); end
        rd(BASE + 8'd1, d0, d1);
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL ack_pend: got %h want 00", d0); end
    endtask

    task automatic test_priority();
        logic [7:0] d0, d1;
        do_reset();
        wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
        req = 8'h24; tick(4);
        checks++; if (irq0 !== 1'b1 || vect0 !== 4'h2) begin errors++; $display("FAIL prio_first: got irq %b vect %h want 1/2", irq0, vect0); end
        ack_cpu(); req = 8'h00; tick(3);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL prio_blocked: got %b want 0", irq0); end
        rd(BASE + 8'd1, d0, d1);
        checks++; if (d0 !== 8'h20) begin errors++; $display("FAIL prio_pend: got %h want 20", d0); end
        wr(BASE + 8'd2, 8'h00); tick(1);
        checks++; if (irq0 !== 1'b1 || vect0 !== 4'h5) begin errors++; $display("FAIL prio_after_eoi: got irq %b vect %h want 1/5", irq0, vect0); end
    endtask

    task automatic test_nested();
        logic [7:0] d0, d1;
        do_reset();
        wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
        req = 8'h20; tick(4); ack_cpu(); req = 8'h00; tick(2);
        rd(BASE + 8'd2, d0, d1);
        checks++; if (d0 !== 8'h20) begin errors++; $display("FAIL nest_isr: got %h want 20", d0); end
        req = 8'h40; tick(5);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL nest_low_blocked: got %b want 0", irq0); end
        req = 8'h42; tick(4);
        checks++; if (irq0 !== 1'b1 || vect0 !== 4'h1) begin errors++; $display("FAIL nest_high: got irq %b vect %h want 1/1", irq0, vect0); end
        ack_cpu();
        rd(BASE + 8'd2, d0, d1);
        checks++; if (d0 !== 8'h22) begin errors++; $display("FAIL nest_isr2: got %h want 22", d0); end
        req = 8'h00;
    endtask

    task automatic test_level_drop();
        logic [7:0] d0, d1;
        int n;
        do_reset();
        wr(BASE, 8'h00);
        req = 8'h01; tick(4);
        checks++; if (irq0 !== 1'b1 || vect0 !== 4'h0) begin errors++; $display("FAIL level_irq: got irq %b vect %h want 1/0", irq0, vect0); end
        req = 8'h00;
        n = 0;
        while (irq0 === 1'b1 && n < 3) begin tick(1); n++; end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL level_drop: got %b want 0 within 3 edges", irq0); end
        rd(BASE + 8'd2, d0, d1);
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL level_isr: got %h want 00", d0); end
    endtask

    task automatic test_rotate();
        logic [7:0] d0, d1, r;
        int a, exp;
        do_reset();
        wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
        req = 8'h04; tick(4);
        checks++; if (irq1 !== 1'b1 || vect1 !== 4'hE) begin errors++; $display("FAIL rot_first: got irq %b vect %h want 1/e", irq1, vect1); end
        ack_cpu(); wr(BASE + 8'd2, 8'h00); req = 8'h00; tick(3);
        req = 8'h12; tick(4);
        checks++; if (irq1 !== 1'b1 || vect1 !== 4'h0) begin errors++; $display("FAIL rot_low3: got irq %b vect %h want 1/0", irq1, vect1); end
        checks++; if (vect0 !== 4'h1) begin errors++; $display("FAIL fixed_vs_rot: got %h want 1", vect0); end
        for (int it = 0; it < 4; it++) begin
            do_reset();
            wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
            a = $urandom_range(0, 7);
            req = 8'd1 << a; tick(4); ack_cpu();
            wr(BASE + 8'd2, 8'h00); req = 8'h00; tick(3);
            rd(BASE + 8'd2, d0, d1);
            checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rot_eoi_isr: got %h want 00", d1); end
            r = 8'($urandom_range(1, 255));
            req = r; tick(4);
            exp = first_ch(r, (a + 1) % 8);
            checks++; if (irq1 !== 1'b1 || vect1 !== 4'(VB1 + 4'(exp))) begin errors++; $display("FAIL rot_rand: a %0d req %h got irq %b vect %h want vect %h", a, r, irq1, vect1, 4'(VB1 + 4'(exp))); end
            req = 8'h00;
        end
    endtask

    task automatic test_random_fixed();
        logic [7:0] d0, d1, m, r, left;
        int c;
        for (int it = 0; it < 5; it++) begin
            do_reset();
            m = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            r = 8'($urandom_range(1, 255));
            wr(BASE, m); wr(BASE + 8'd3, 8'hFF);
            req = r; tick(4);
            rd(BASE + 8'd1, d0, d1);
            checks++; if (d0 !== r) begin errors++; $display("FAIL rand_pend: got %h want %h", d0, r); end
            req = 8'h00;
            left = r & ~m;
            for (int n = 0; n < 8 && left != 8'h00; n++) begin
                c = first_ch(left, 0);
                checks++; if (irq0 !== 1'b1 || vect0 !== 4'(c)) begin errors++; $display("FAIL rand_serve: mask %h req %h got irq %b vect %h want 1/%0d", m, r, irq0, vect0, c); end
                ack_cpu();
                left[c] = 1'b0;
                wr(BASE + 8'd2, 8'h00); tick(1);
            end
            checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rand_done_irq: got %b want 0", irq0); end
            rd(BASE + 8'd1, d0, d1);
            checks++; if (d0 !== (r & m)) begin errors++; $display("FAIL rand_masked_pend: got %h want %h", d0, r & m); end
        end
    endtask

    task automatic test_w1c_ce();
        logic [7:0] d0, d1;
        do_reset();
        wr(BASE + 8'd3, 8'hFF);
        req = 8'h81; tick(3); req = 8'h00;
        rd(BASE + 8'd1, d0, d1);
        checks++; if (d0 !== 8'h81) begin errors++; $display("FAIL w1c_before: got %h want 81", d0); end
        wr(BASE + 8'd1, 8'h01);
        rd(BASE + 8'd1, d0, d1);
        checks++; if (d0 !== 8'h80) begin errors++; $display("FAIL w1c_after: got %h want 80", d0); end
        do_reset();
        ce = 1'b0; wr(BASE, 8'h00); ce = 1'b1;
        rd(BASE, d0, d1);
        checks++; if (d0 !== 8'hFF) begin errors++; $display("FAIL ce_write: got %h want ff", d0); end
        wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
        ce = 1'b0; req = 8'h08; tick(6);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL ce_frozen: got %b want 0", irq0); end
        ce = 1'b1; tick(2);
        checks++; if (irq0 !== 1'b1 || vect0 !== 4'h3) begin errors++; $display("FAIL ce_resume: got irq %b vect %h want 1/3", irq0, vect0); end
        req = 8'h00;
    endtask

    task automatic test_reset_mid_assert();
        logic [7:0] d0, d1;
        do_reset();
        wr(BASE, 8'h00); wr(BASE + 8'd3, 8'hFF);
        req = 8'h10; tick(4);
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", irq0); end
        #2 reset = 1'b1;
        #1;
        checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0 || vect0 !== 4'h0) begin errors++; $display("FAIL mid_reset_out: got irq %b/%b vect %h want 0/0/0", irq0, irq1, vect0); end
        rd(BASE, d0, d1);
        checks++; if (d0 !== 8'hFF) begin errors++; $display("FAIL mid_reset_mask: got %h want ff", d0); end
        tick(1);
        reset = 1'b0; req = 8'h00; tick(2);
        req = 8'h10; tick(5);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL mid_post_masked: got %b want 0", irq0); end
        req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority();
        test_nested();
        test_level_drop();
        test_rotate();
        test_random_fixed();
        test_w1c_ce();
        test_reset_mid_assert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
